tdc_link_host: RTL and testbench
================================

# tdc_link_host

Synthesizable host-side endpoint for the delay-line TDC's UART command link. It serializes a trigger byte onto the TDC's receive line and waits for the single response byte carrying the encoded stage position. It deserializes that byte, validates it, and reports position, error or timeout. It sits on a second FPGA or in the bench harness, facing the TDC top's serial pins.

## Interface
Parameters:
- CLKS_PER_BIT, 217: clock cycles per UART bit (8N1, LSB first).
- TIMEOUT_CYCLES, 1000000: cycles to wait for a response start bit; must be ≥ 2·CLKS_PER_BIT.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request to send req_byte.
- req_ready  out  1  high only in IDLE.
- req_byte  in  8  trigger byte to transmit.
- tx  out  1  serial out, drives the TDC's uart_rx; idle high.
- rx  in  1  serial in, from the TDC's uart_tx; asynchronous.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_position  out  4  low nibble of the received byte; 0 on timeout.
- rsp_error  out  1  framing or range error; qualified by rsp_valid.
- rsp_timeout  out  1  no start bit within TIMEOUT_CYCLES; qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset (asynchronous, while reset=0):
  - State goes to IDLE.
  - Outputs: tx=1, rsp_valid=0, rsp_position=0, rsp_error=0, rsp_timeout=0, busy=0, req_ready=1.
  - Counters clear and the synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer preset to 1. All rx decisions use the synchronized value.
- States:
  - IDLE: accept when req_valid && req_ready, latch req_byte, go to SEND.
  - SEND: shift out start(0), d0..d7, stop(1), each held CLKS_PER_BIT cycles. After the stop bit has been held CLKS_PER_BIT/2 cycles, go to WAIT_RSP; tx stays 1 from then on. rx is ignored in SEND.
  - WAIT_RSP: the timeout counter runs from entry.
    - A 1→0 transition on synchronized rx goes to RECV.
    - If the counter reaches TIMEOUT_CYCLES, go to DONE with timeout set.
  - RECV: wait CLKS_PER_BIT/2 cycles, then re-sample.
    - If rx is high, it was a false start: return to WAIT_RSP without restarting the timeout counter.
    - Otherwise sample d0..d7 and then the stop bit, each CLKS_PER_BIT apart at mid-bit. Go to DONE.
  - DONE: one cycle, with rsp_valid=1, then IDLE.
- Response checks:
  - rsp_position = byte[3:0].
  - rsp_error = (stop bit == 0) OR (byte[7:4] != 0) OR (byte[3:0] > 10).
  - On timeout: rsp_position=0, rsp_error=0, rsp_timeout=1.
- rsp_position, rsp_error and rsp_timeout hold their values until the next DONE.
- req_valid outside IDLE is ignored; there is no queuing.

## Timing
- Accept edge → tx falls on the next clk edge (1 cycle).
- Serial bit widths:
  - Start bit and each data bit: exactly CLKS_PER_BIT cycles.
  - Stop bit before WAIT_RSP: CLKS_PER_BIT/2 cycles, using integer floor.
- Response latency: rsp_valid rises 1 cycle after the stop-bit sample cycle.
- Response start-bit detection is delayed by up to 3 cycles (2-cycle synchronizer plus edge detect). Mid-bit sampling absorbs this.
- Timeout: rsp_valid rises exactly TIMEOUT_CYCLES+1 cycles after WAIT_RSP entry.
- Minimum spacing between accepted requests: the full transaction plus 1 IDLE cycle. req_ready rises in the cycle after DONE.
- Reset asserted mid-transaction aborts immediately. No rsp_valid is produced for the aborted request.

## Structure
- Shared package tdc_link_pkg holds:
  - state enum {IDLE, SEND, WAIT_RSP, RECV, DONE};
  - localparam POS_W=4;
  - localparam MAX_POSITION=10 (the TDC stage count).
- One sub-module, tdc_link_rx_deser, contains:
  - the synchronizer;
  - start detect and mid-bit sampling;
  - an 8-bit shift register;
  - outputs byte_valid, byte, framing_err and start_seen.
- The top FSM, transmit shifter, baud counter and timeout counter stay in tdc_link_host.

## Test plan
Use CLKS_PER_BIT=4 and TIMEOUT_CYCLES=200.
- Reset: hold reset=0 mid-SEND → tx=1 and busy=0 immediately. After release, req_ready=1 and rsp_valid never fires.
- Transmit: req_byte=0xA5 → tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
- Good response: the responder model sends 0x07 → a single rsp_valid pulse with rsp_position=7, rsp_error=0, rsp_timeout=0.
- Bad responses, each giving rsp_error=1:
  - 0x0B (rsp_position=11);
  - 0x13 (rsp_position=3);
  - 0x05 with stop bit 0 (rsp_position=5).
- Timeout: rx held high → rsp_valid with rsp_timeout=1 and rsp_position=0, exactly 201 cycles after WAIT_RSP entry.
- Glitch: rx low for 1 cycle in WAIT_RSP → returns to WAIT_RSP. A following valid 0x04 yields rsp_position=4. req_valid pulsed while busy is not accepted.

Source files
------------

// File: rtl/tdc_link_pkg.sv
// Shared types and constants for the TDC command-link host endpoint.
package tdc_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    RECV,
    DONE
  } link_state_e;

  // Width of the reported stage position.
  localparam int POS_W = 4;

  // Number of stages in the TDC delay line; a larger position is out of range.
  localparam int MAX_POSITION = 10;

  // True when a response byte encodes a legal stage position.
  function automatic logic pos_in_range(input logic [7:0] rsp_byte);
    return (rsp_byte[7:POS_W] == '0) &&
           (rsp_byte[POS_W-1:0] <= POS_W'(MAX_POSITION));
  endfunction

endpackage

// File: rtl/tdc_link_rx_deser.sv
// Response-line deserializer: synchronizes rx, detects the start bit while
// armed, samples each bit at mid-bit and assembles the byte LSB first.
// start_seen, false_start and byte_valid are single-cycle strobes decoded
// from the sampling state so the host FSM can react in the same cycle.
module tdc_link_rx_deser
  import tdc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       arm,
  output logic       start_seen,
  output logic       false_start,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Bit slot 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  localparam logic [3:0] SLOT_START = 4'd0;
  localparam logic [3:0] SLOT_STOP  = 4'd9;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_p2;
  logic             fall;
  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       slot;
  logic [7:0]       shift;
  logic             sample_now;

  // Synchronizer stage: two flops into the clock domain, a third for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall       = rx_p2 & ~rx_p1;
  assign sample_now = active &&
                      (cnt == ((slot == SLOT_START) ? HALF_LAST : BIT_LAST));

  assign start_seen  = arm & ~active & fall;
  assign false_start = sample_now & (slot == SLOT_START) & rx_p1;
  assign byte_valid  = sample_now & (slot == SLOT_STOP);
  assign framing_err = ~rx_p1;
  assign rx_byte     = shift;

  // Sampling control: half a bit to the start-bit centre, then whole bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cnt    <= '0;
      slot   <= SLOT_START;
    end else if (start_seen) begin
      active <= 1'b1;
      cnt    <= '0;
      slot   <= SLOT_START;
    end else if (sample_now) begin
      cnt <= '0;
      if (slot == SLOT_START) begin
        if (rx_p1) begin
          active <= 1'b0;
        end else begin
          slot <= slot + 4'd1;
        end
      end else if (slot == SLOT_STOP) begin
        active <= 1'b0;
      end else begin
        slot <= slot + 4'd1;
      end
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Data shift register: each mid-bit data sample enters at the MSB
  always_ff @(posedge clk) begin
    if (sample_now && (slot != SLOT_START) && (slot != SLOT_STOP)) begin
      shift <= {rx_p1, shift[7:1]};
    end
  end

endmodule

// File: rtl/tdc_link_host.sv
// Host-side endpoint of the TDC UART command link. Sends one trigger byte,
// waits for the single response byte, and reports the decoded stage
// position, a framing/range error, or a timeout with a one-cycle pulse.
module tdc_link_host
  import tdc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 217,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_byte,
  output logic             tx,
  input  logic             rx,
  output logic             rsp_valid,
  output logic [POS_W-1:0] rsp_position,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       SLOT_STOP = 4'd9;

  link_state_e      state;
  logic [8:0]       tx_shift;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       tx_slot;
  logic [TO_W-1:0]  to_cnt;

  logic             start_seen;
  logic             false_start;
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             framing_err;

  // A response is bad if the stop bit was low or the byte is not a legal position.
  function automatic logic rsp_bad(input logic [7:0] b, input logic stop_low);
    return stop_low || !pos_in_range(b);
  endfunction

  tdc_link_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_deser (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .arm        (state == WAIT_RSP),
    .start_seen (start_seen),
    .false_start(false_start),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .framing_err(framing_err)
  );

  // Link FSM with transmit shifter, baud and timeout counters, registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      tx_shift     <= '1;
      baud_cnt     <= '0;
      tx_slot      <= '0;
      to_cnt       <= '0;
      rsp_valid    <= 1'b0;
      rsp_position <= '0;
      rsp_error    <= 1'b0;
      rsp_timeout  <= 1'b0;
      busy         <= 1'b0;
      req_ready    <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            tx_shift  <= {1'b1, req_byte};
            tx        <= 1'b0;
            baud_cnt  <= '0;
            tx_slot   <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          // The stop bit is cut to half a bit; the line then simply stays high.
          if ((tx_slot == SLOT_STOP) && (baud_cnt == HALF_LAST)) begin
            tx     <= 1'b1;
            to_cnt <= '0;
            state  <= WAIT_RSP;
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            tx_slot  <= tx_slot + 4'd1;
            tx       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        WAIT_RSP: begin
          if (start_seen) begin
            state <= RECV;
          end else if (to_cnt == TO_LAST) begin
            rsp_valid    <= 1'b1;
            rsp_position <= '0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b1;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RECV: begin
          // A false start resumes waiting with the timeout count preserved.
          if (false_start) begin
            state <= WAIT_RSP;
          end else if (byte_valid) begin
            rsp_valid    <= 1'b1;
            rsp_position <= rx_byte[POS_W-1:0];
            rsp_error    <= rsp_bad(rx_byte, framing_err);
            rsp_timeout  <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          tx        <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_link_host.sv
// Bench for tdc_link_host: directed and randomized transactions against a
// responder model, with expected responses computed from the link rules.
module tb_tdc_link_host;

  localparam int CPB  = 4;
  localparam int TMO  = 200;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_byte;
  logic       tx;
  logic       rx;
  logic       rsp_valid;
  logic [3:0] rsp_position;
  logic       rsp_error;
  logic       rsp_timeout;
  logic       busy;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         vld_count = 0;
  logic [3:0] cap_pos;
  logic       cap_err;
  logic       cap_tmo;

  always #5 clk = ~clk;

  tdc_link_host #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_byte    (req_byte),
    .tx          (tx),
    .rx          (rx),
    .rsp_valid   (rsp_valid),
    .rsp_position(rsp_position),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  // Capture every response pulse and the values it carries
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      vld_count <= vld_count + 1;
      cap_pos   <= rsp_position;
      cap_err   <= rsp_error;
      cap_tmo   <= rsp_timeout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected response from the reply byte, its stop bit and whether it timed out
  function automatic void model_rsp(input int b, input bit stop_ok, input bit timed_out,
                                    output int pos, output int err);
    if (timed_out) begin
      pos = 0;
      err = 0;
    end else begin
      pos = b % 16;
      err = (!stop_ok || (b / 16) != 0 || (b % 16) > 10) ? 1 : 0;
    end
  endfunction

  // Responder: drives one 8N1 frame on rx, starting at the current negedge
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // mode 0: reply, mode 1: stay silent, mode 2: glitch + busy request, then reply
  task automatic run_txn(input logic [7:0] req, input int mode, input logic [7:0] rsp,
                         input bit stop_ok);
    logic [9:0] frame;
    int idx, k, c0, exp_pos, exp_err;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_ready_idle", req_ready, 1);
    c0 = vld_count;
    req_byte  = req;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_byte  = 8'($urandom);
    check_eq("busy_send", busy, 1);
    check_eq("req_ready_send", req_ready, 0);
    frame = {1'b1, req, 1'b0};
    idx = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) begin
          @(negedge clk);
          idx++;
        end
        check_eq("tx_bit", tx, frame[b]);
      end
    end
    if (mode == 1) begin
      while (rsp_valid !== 1'b1 && idx < 1000) begin
        @(negedge clk);
        idx++;
      end
      check_eq("tmo_latency", idx, 9 * CPB + HALF + TMO + 1);
    end else begin
      if (mode == 2) begin
        rx = 1'b0;
        @(negedge clk);
        rx        = 1'b1;
        req_valid = 1'b1;
        req_byte  = 8'h3C;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("glitch_busy", busy, 1);
        check_eq("glitch_no_rsp", vld_count, c0);
        check_eq("glitch_tx_idle", tx, 1);
      end
      send_frame(rsp, stop_ok);
      k = 0;
      while (vld_count == c0 && k < 4 * CPB) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (2) @(negedge clk);
    check_eq("rsp_pulses", vld_count - c0, 1);
    model_rsp(rsp, stop_ok, mode == 1, exp_pos, exp_err);
    check_eq("rsp_position", cap_pos, exp_pos);
    check_eq("rsp_error", cap_err, exp_err);
    check_eq("rsp_timeout", cap_tmo, (mode == 1) ? 1 : 0);
    check_eq("hold_position", rsp_position, exp_pos);
    check_eq("ready_after", req_ready, 1);
    check_eq("busy_after", busy, 0);
    if (mode == 2) begin
      repeat (6) @(negedge clk);
      check_eq("busy_req_ignored", busy, 0);
      check_eq("tx_idle_after", tx, 1);
    end
  endtask

  task automatic reset_mid_send();
    int c0, k;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    req_byte  = 8'h00;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    check_eq("pre_reset_tx", tx, 0);
    c0 = vld_count;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (9 * CPB + TMO + 60) @(negedge clk);
    check_eq("rst_no_rsp", vld_count, c0);
    check_eq("rst_ready_after", req_ready, 1);
    check_eq("rst_tx_after", tx, 1);
  endtask

  initial begin
    reset     = 1'b0;
    rx        = 1'b1;
    req_valid = 1'b0;
    req_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", tx, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_req_ready", req_ready, 1);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_position", rsp_position, 0);
    check_eq("reset_error", rsp_error, 0);
    check_eq("reset_timeout", rsp_timeout, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(8'hA5, 0, 8'h07, 1'b1);
    run_txn(8'h11, 0, 8'h0B, 1'b1);
    run_txn(8'h22, 0, 8'h13, 1'b1);
    run_txn(8'h33, 0, 8'h05, 1'b0);
    run_txn(8'h44, 1, 8'h00, 1'b1);
    run_txn(8'h55, 2, 8'h04, 1'b1);
    run_txn(8'hFF, 0, 8'h0A, 1'b1);
    run_txn(8'h00, 0, 8'h00, 1'b1);

    reset_mid_send();

    for (int t = 0; t < 16; t++) begin
      int         m;
      int         mode;
      logic [7:0] rb;
      bit         st;
      m    = int'($urandom_range(0, 9));
      rb   = 8'($urandom);
      st   = 1'b1;
      mode = 0;
      if (m <= 4) begin
        rb = 8'($urandom_range(0, 10));
      end else if (m == 7) begin
        st = 1'b0;
      end else if (m == 8) begin
        mode = 1;
      end else if (m == 9) begin
        mode = 2;
      end
      run_txn(8'($urandom), mode, rb, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
